regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the 32-bit pipeline, succeeding the fixed 32x32 two-read file. It adds a configurable width, depth and read-port count, a synchronous initialisation sequencer that loads architectural reset values one entry per cycle, and a per-register busy scoreboard for hazard detection. Decode uses this block for operand reads; writeback uses it for result commits.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers; power of two, at least 16; AW = clog2(DEPTH)
- NUM_RD, 2, number of read ports, 1..4
- clock  in  1  single clock; all state updates on its rising edge
- clear  in  1  reset, synchronous and active-high
- ready  out  1  high once initialisation has completed
- rd_addr  in  NUM_RD*AW  flattened read addresses; port p uses bits [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  flattened read data, combinational
- rd_busy  out  NUM_RD  scoreboard busy bit of each read address
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rsv_en  in  1  reserve a destination; sets its busy bit
- rsv_addr  in  AW  address to reserve

## Operation
- States: INIT and RUN.
  - clear high: state INIT, init index 0, all busy bits 0, ready 0.
  - INIT with clear low: each cycle, write entry[idx] = INIT_VAL(idx), then idx increments.
  - After entry DEPTH-1 is written: go to RUN and set ready to 1.
- INIT_VAL comes from the package:
  - entry 1 = 1, entry 2 = 2, entry 10 = 32'h1001_0000, truncated to WIDTH.
  - All other entries = 0.
- During INIT:
  - wr_en and rsv_en are ignored.
  - rd_data is all 0 and rd_busy is all 0.
- RUN writes: when wr_en is high and wr_addr != 0, entry[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- RUN reservations: when rsv_en is high and rsv_addr != 0, busy[rsv_addr] <= 1.
- Reservation and write to the same address in the same cycle: the busy bit ends at 1, because the new producer wins. The data write still occurs.
- Register 0:
  - Reads return 0.
  - Writes and reservations to it are discarded.
  - Its busy bit is always 0.
- Read ports are independent. Several ports may read the same address.
- clear asserted mid-operation (INIT or RUN) restarts INIT from index 0 on the next edge. Any write in that cycle is dropped.

## Timing
- Reset values: ready = 0, busy = all 0, state = INIT, idx = 0. rd_data reads 0 until ready is high.
- Initialisation latency: ready rises on the DEPTH-th rising edge after clear goes low. For DEPTH = 32, that is 32 cycles.
- Reads are combinational from the current storage and busy bits. There is no read latency.
- Writes commit on the rising edge. Without bypass, the written value is visible on rd_data in the following cycle.
- Busy set and busy clear both take effect at the edge. rd_busy reflects the registered bit, except where bypass applies.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Applies when a read port matches wr_addr, wr_en is high, the address is nonzero, and the state is RUN.
  - That port returns wr_data combinationally in the same cycle.
  - That port's rd_busy is forced to 0 in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - rd_data is always taken from storage.
  - rd_busy is always the registered bit.
  - The pipeline must handle write-to-read hazards by stalling.

## Structure
- Package regfile_pkg holds:
  - The INIT_VAL function or constants, with indices 1, 2 and 10.
  - The state enum (INIT, RUN).
  - Default WIDTH/DEPTH localparams.
- Sub-module regfile_init_seq implements the INIT/RUN state machine, the index counter and ready. It outputs init_we, init_addr and init_data to the storage write mux.
- Storage, scoreboard and read muxes live in regfile_mp.

## Test plan
- **Init:** pulse clear for 2 cycles, then hold low.
  - ready must be 0 for exactly 32 edges, then 1.
  - Reads must then return entry 1 = 1, entry 2 = 2, entry 10 = 32'h1001_0000, entry 5 = 0.
- **Write/read:** in RUN, write 32'hDEAD_BEEF to entry 7.
  - In the same cycle, port 0 reading 7 returns the old value 0 without bypass, or 32'hDEAD_BEEF with bypass.
  - In the next cycle, both builds return 32'hDEAD_BEEF.
- **Register 0:** write 32'hFFFF_FFFF and reserve address 0.
  - Reads of 0 return 0.
  - rd_busy for address 0 stays 0.
- **Scoreboard:**
  - Reserve 12: rd_busy for 12 is 1 from the next cycle.
  - Write 12: busy is 0 the cycle after, or in the same cycle with bypass.
  - Reserve and write 12 simultaneously: busy remains 1 and the data is updated.
- **Mid-operation clear:** write entry 3 = 9, then assert clear in RUN.
  - ready drops to 0 on the next edge and init restarts.
  - After completion, entry 3 = 0 and all busy bits are 0.
- **Multi-port, NUM_RD = 4:** all ports read 10 while port 3 reads 0.
  - Ports 0..2 return 32'h1001_0000.
  - Port 3 returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-read-port register file.
//   rf_state_e     - sequencer states (INIT loads reset values, RUN is normal use)
//   DEFAULT_WIDTH  - default data width
//   DEFAULT_DEPTH  - default register count
//   init_val()     - architectural reset value of a register index (32-bit form;
//                    callers truncate/extend to their WIDTH)
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  function automatic logic [31:0] init_val(input int unsigned idx);
    case (idx)
      1:       return 32'd1;
      2:       return 32'd2;
      10:      return 32'h1001_0000;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: INIT/RUN sequencer for regfile_mp.
// After clear deasserts, writes init_val(idx) to one entry per cycle for
// idx = 0..DEPTH-1, then enters RUN and raises ready.
// Ports:
//   clock      - rising-edge clock
//   clear      - synchronous active-high reset; restarts the sequence
//   ready      - high in RUN
//   init_we    - storage write strobe from the sequencer
//   init_addr  - entry being initialised
//   init_data  - reset value for init_addr, sized to WIDTH
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  output logic             ready,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data
);

  rf_state_e     state, state_nx;
  logic [AW-1:0] idx, idx_nx;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    init_we   = 1'b0;
    init_addr = idx;
    init_data = WIDTH'(init_val(32'(idx)));
    case (state)
      INIT: begin
        init_we = !clear;
        idx_nx  = idx + AW'(1);
        if (idx == AW'(DEPTH - 1)) state_nx = RUN;
      end
      RUN: begin
      end
      default: state_nx = INIT;
    endcase
  end

  assign ready = (state == RUN);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD combinational read ports,
// one write port, a per-register busy scoreboard and a synchronous
// initialisation sequencer.
// Optional feature: define REGFILE_BYPASS_EN to forward wr_data (and clear the
// busy indication) to read ports addressing the register being written.
// Ports:
//   clock    - rising-edge clock
//   clear    - synchronous active-high reset, restarts initialisation
//   ready    - high once initialisation has completed
//   rd_addr  - NUM_RD flattened read addresses, port p at [p*AW +: AW]
//   rd_data  - NUM_RD flattened read data, port p at [p*WIDTH +: WIDTH]
//   rd_busy  - scoreboard busy bit per read port
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rsv_en   - reserve a destination (set its busy bit)
//   rsv_addr - address to reserve
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned NUM_RD = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    clear,
  output logic                    ready,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;

  logic run_we;
  logic rsv_ok;
  logic [AW-1:0] ra;

  regfile_init_seq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_seq (
    .clock     (clock),
    .clear     (clear),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  assign run_we = ready && !clear && wr_en && (wr_addr != '0);
  assign rsv_ok = ready && rsv_en && (rsv_addr != '0);

  // Sequencer and run-time writes are mutually exclusive by state.
  always_ff @(posedge clock) begin
    if (init_we)     mem[init_addr] <= init_data;
    else if (run_we) mem[wr_addr]   <= wr_data;
  end

  // Reservation is applied after the write clear so a same-cycle
  // reserve of the written address leaves the bit set.
  always_ff @(posedge clock) begin
    if (clear) begin
      busy <= '0;
    end else begin
      if (run_we) busy[wr_addr]  <= 1'b0;
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (ready && (ra != '0)) begin
        rd_data[p*WIDTH +: WIDTH] = mem[ra];
        rd_busy[p]                = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == ra)) begin
          rd_data[p*WIDTH +: WIDTH] = wr_data;
          rd_busy[p]                = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int NRD = 4;
  localparam int DEP = 32;

  logic            clock = 1'b0;
  logic            clear;
  logic            ready;
  logic [NRD*5-1:0]  rd_addr;
  logic [NRD*32-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [31:0]     wr_data;
  logic            rsv_en;
  logic [4:0]      rsv_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents, busy flags, init progress.
  logic [31:0] m_mem [DEP];
  bit          m_busy [DEP];
  bit          m_ready;
  int          m_cnt;

  always #5 clock = ~clock;

  regfile_mp #(
    .WIDTH  (32),
    .DEPTH  (DEP),
    .NUM_RD (NRD)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  function automatic logic [31:0] ref_init(int i);
    if (i == 1)  return 32'd1;
    if (i == 2)  return 32'd2;
    if (i == 10) return 32'h1001_0000;
    return 32'd0;
  endfunction

  function automatic logic [4:0] port_addr(int p);
    return rd_addr[p*5 +: 5];
  endfunction

  function automatic logic [31:0] exp_data(int p);
    logic [4:0] a;
    a = port_addr(p);
    if (!m_ready || a == 5'd0) return 32'd0;
    if (BYP && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int p);
    logic [4:0] a;
    a = port_addr(p);
    if (!m_ready || a == 5'd0) return 1'b0;
    if (BYP && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic set_rd(int p, logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
  endtask

  // Advance one clock edge and apply the model's rules for the inputs held
  // across that edge; returns 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    if (clear) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < DEP; i++) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = ref_init(m_cnt);
      m_cnt++;
      if (m_cnt == DEP) m_ready = 1'b1;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    idle();
    rd_addr = '0;
    for (int i = 0; i < DEP; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    m_ready = 1'b0;
    m_cnt = 0;
    step();
    step();
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b want 0", ready);
    end
    n_checks++;
    if (rd_busy !== 4'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0000", rd_busy);
    end
  endtask

  task automatic test_init();
    clear = 1'b0;
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd10); set_rd(3, 5'd5);
    for (int e = 1; e <= DEP; e++) begin
      // Attempts to write/reserve during INIT must be ignored.
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hABCD_0123;
      rsv_en = 1'b1; rsv_addr = 5'd1;
      #1;
      n_checks++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        n_fail++; $display("FAIL init_reads edge %0d got %h/%b want 0/0", e, rd_data, rd_busy);
      end
      idle();
      step();
      n_checks++;
      if (ready !== (e == DEP)) begin
        n_fail++; $display("FAIL init_ready after edge %0d got %b want %b", e, ready, e == DEP);
      end
    end
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'd1) begin
      n_fail++; $display("FAIL init_e1 got %h want 1", rd_data[31:0]);
    end
    n_checks++;
    if (rd_data[63:32] !== 32'd2) begin
      n_fail++; $display("FAIL init_e2 got %h want 2", rd_data[63:32]);
    end
    n_checks++;
    if (rd_data[95:64] !== 32'h1001_0000) begin
      n_fail++; $display("FAIL init_e10 got %h want 10010000", rd_data[95:64]);
    end
    n_checks++;
    if (rd_data[127:96] !== 32'd0) begin
      n_fail++; $display("FAIL init_e5 got %h want 0", rd_data[127:96]);
    end
    n_checks++;
    if (rd_busy !== 4'b0) begin
      n_fail++; $display("FAIL init_busy got %b want 0000", rd_busy);
    end
  endtask

  task automatic test_write_read();
    set_rd(0, 5'd7);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (rd_data[31:0] !== (BYP ? 32'hDEAD_BEEF : 32'd0)) begin
      n_fail++; $display("FAIL wr_same_cycle got %h want %h", rd_data[31:0], BYP ? 32'hDEAD_BEEF : 32'd0);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_next_cycle got %h want deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_reg0();
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    n_checks++;
    if (rd_data[63:0] !== 64'd0 || rd_busy[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL r0_same got %h/%b want 0/00", rd_data[63:0], rd_busy[1:0]);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rd_data[63:0] !== 64'd0 || rd_busy[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL r0_next got %h/%b want 0/00", rd_data[63:0], rd_busy[1:0]);
    end
  endtask

  task automatic test_scoreboard();
    set_rd(1, 5'd12);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL sb_rsv_same got %b want 0", rd_busy[1]);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL sb_rsv_next got %b want 1", rd_busy[1]);
    end
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_1234;
    #1;
    n_checks++;
    if (rd_busy[1] !== !BYP) begin
      n_fail++; $display("FAIL sb_wr_same got %b want %b", rd_busy[1], !BYP);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL sb_wr_next got %b want 0", rd_busy[1]);
    end
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_5555;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    step();
    idle();
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1 || rd_data[63:32] !== 32'h0000_5555) begin
      n_fail++; $display("FAIL sb_both got %b/%h want 1/00005555", rd_busy[1], rd_data[63:32]);
    end
  endtask

  task automatic test_multiport();
    set_rd(0, 5'd10); set_rd(1, 5'd10); set_rd(2, 5'd10); set_rd(3, 5'd0);
    #1;
    for (int p = 0; p < 3; p++) begin
      n_checks++;
      if (rd_data[p*32 +: 32] !== 32'h1001_0000) begin
        n_fail++; $display("FAIL mp_port%0d got %h want 10010000", p, rd_data[p*32 +: 32]);
      end
    end
    n_checks++;
    if (rd_data[127:96] !== 32'd0) begin
      n_fail++; $display("FAIL mp_port3 got %h want 0", rd_data[127:96]);
    end
  endtask

  task automatic test_mid_clear();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd9;
    rsv_en = 1'b1; rsv_addr = 5'd20;
    step();
    idle();
    set_rd(0, 5'd3);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'd9) begin
      n_fail++; $display("FAIL mc_pre got %h want 9", rd_data[31:0]);
    end
    clear = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
    step();
    idle();
    clear = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL mc_drop got %b want 0", ready);
    end
    for (int e = 1; e <= DEP; e++) begin
      step();
      n_checks++;
      if (ready !== (e == DEP)) begin
        n_fail++; $display("FAIL mc_ready after edge %0d got %b want %b", e, ready, e == DEP);
      end
    end
    for (int a = 0; a < DEP; a++) begin
      set_rd(0, 5'(a));
      #1;
      n_checks++;
      if (rd_data[31:0] !== ref_init(a) || rd_busy[0] !== 1'b0) begin
        n_fail++; $display("FAIL mc_entry%0d got %h/%b want %h/0", a, rd_data[31:0], rd_busy[0], ref_init(a));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clear    = ($urandom_range(0, 99) == 0);
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 31));
      for (int p = 0; p < NRD; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31)));
      #1;
      n_checks++;
      if (ready !== m_ready) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, ready, m_ready);
      end
      for (int p = 0; p < NRD; p++) begin
        n_checks++;
        if (rd_data[p*32 +: 32] !== exp_data(p) || rd_busy[p] !== exp_busy(p)) begin
          n_fail++;
          $display("FAIL rnd_port%0d cyc %0d addr %0d got %h/%b want %h/%b",
                   p, c, port_addr(p), rd_data[p*32 +: 32], rd_busy[p], exp_data(p), exp_busy(p));
        end
      end
      step();
    end
    clear = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_reg0();
    test_scoreboard();
    test_multiport();
    test_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
